d_flip_flop: RTL and testbench

Parameterizable, positive-edge D-type register with asynchronous active-low reset. It is the basic storage/pipeline element of the design. Default configuration is a single-bit, single-stage flop: q equals the d sampled at the previous rising clock edge. Optional width and stage count let the same block serve as a multi-bit register or a short reset-clearable delay line.

---
 rtl/flip_flop_pkg.sv | 12 +
 rtl/d_flip_flop_stage.sv | 34 +++
 rtl/d_flip_flop.sv | 92 +++++++++
 tb/tb_d_flip_flop.sv | 126 ++++++++++++
 4 files changed

// File: rtl/flip_flop_pkg.sv
// Shared definitions for the d_flip_flop register family: default geometry
// and the default-width data type.
package flip_flop_pkg;

    // Default configuration is a single-bit, single-stage flop.
    localparam int DEFAULT_WIDTH  = 1;
    localparam int DEFAULT_STAGES = 1;

    // Data type matching the default register width.
    typedef logic [DEFAULT_WIDTH-1:0] flop_data_t;

endpackage : flip_flop_pkg

// File: rtl/d_flip_flop_stage.sv
// One WIDTH-bit positive-edge register with asynchronous active-low reset
// to RESET_VALUE. Building block of the d_flip_flop delay chain.
module d_flip_flop_stage
    import flip_flop_pkg::*;
#(
    parameter int                WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next state is simply the incoming data; no enable, no conditioning.
    always_comb begin
        data_d = d;
    end

    // Storage element; reset is asynchronous and takes priority over the clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : d_flip_flop_stage

// File: rtl/d_flip_flop.sv
// Parameterizable D-type register / short delay line built from STAGES
// chained d_flip_flop_stage instances. q comes straight from the last stage.
// Optional simulation-only checks are enabled by defining FLIP_FLOP_ASSERT_EN.
module d_flip_flop
    import flip_flop_pkg::*;
#(
    parameter int                WIDTH       = DEFAULT_WIDTH,
    parameter int                STAGES      = DEFAULT_STAGES,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reject illegal geometry at elaboration rather than building a broken chain.
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "d_flip_flop: WIDTH must be >= 1 (got %0d)", WIDTH);
    end
    if (STAGES < 1) begin : g_bad_stages
        $fatal(1, "d_flip_flop: STAGES must be >= 1 (got %0d)", STAGES);
    end

    // Output of each stage; stage_q[STAGES-1] drives q.
    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        // The head stage samples the port, every later stage samples its predecessor.
        if (i == 0) begin : g_head
            assign stage_d = d;
        end else begin : g_link
            assign stage_d = stage_q[i-1];
        end

        d_flip_flop_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (stage_d),
            .q       (stage_q[i])
        );
    end

    assign q = stage_q[STAGES-1];

`ifdef FLIP_FLOP_ASSERT_EN
    // Reference history of sampled d, used to confirm the chain latency.
    logic [WIDTH-1:0] hist_q [STAGES];
    int               fill_q;

    // Record every sampled d; contents only matter once fill_q says they are valid.
    always_ff @(posedge clk) begin
        hist_q[0] <= d;
        for (int k = 1; k < STAGES; k++) begin
            hist_q[k] <= hist_q[k-1];
        end
    end

    // Count edges since reset release until the pipeline is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= 0;
        end else if (fill_q < STAGES) begin
            fill_q <= fill_q + 1;
        end
    end

    // Check sampled data, reset value and end-to-end latency at each edge.
    always @(posedge clk) begin
        if (reset_n) begin
            if ($isunknown(d)) begin
                $error("d_flip_flop: d contains X/Z at sampling edge, time %0t", $time);
            end
            if ((fill_q == STAGES) && (q !== hist_q[STAGES-1])) begin
                $error("d_flip_flop: q=%h differs from d sampled %0d edges earlier (%h), time %0t",
                       q, STAGES, hist_q[STAGES-1], $time);
            end
        end else if (q !== RESET_VALUE) begin
            $error("d_flip_flop: q=%h during reset, expected %h, time %0t",
                   q, RESET_VALUE, $time);
        end
    end
`else
    // Checks compiled out; datapath above is identical in both builds.
`endif

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// Directed testbench for d_flip_flop: default flop, 8-bit flop with non-zero
// reset value, and a 3-stage delay line, all sharing one clock and reset.
module tb_d_flip_flop;

    logic       clk;
    logic       reset_n;
    logic       d1, q1;
    logic [7:0] d8, q8;
    logic       d3, q3;

    int checks = 0;
    int errors = 0;

    d_flip_flop u_def (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d1),
        .q       (q1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .STAGES      (1),
        .RESET_VALUE (8'hA5)
    ) u_w8 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d8),
        .q       (q8)
    );

    d_flip_flop #(
        .WIDTH  (1),
        .STAGES (3)
    ) u_dl (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d3),
        .q       (q3)
    );

    // 20 ns period: rising edges at 10, 30, 50 ..., falling at 20, 40 ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        // Reset phase with d toggling underneath.
        reset_n = 1'b0;
        d1 = 1'b0; d8 = 8'h00; d3 = 1'b0;
        #5  d1 = 1'b1;
        #6  chk("rst_q1_edge10", {7'b0, q1}, 8'h00);
            chk("rst_q8_edge10", q8, 8'hA5);
        #4  d1 = 1'b0; d8 = 8'h77; d3 = 1'b1;
        @(negedge clk);                         // t=20
        chk("rst_q1_edge20", {7'b0, q1}, 8'h00);
        chk("rst_q8_edge20", q8, 8'hA5);
        chk("rst_q3_edge20", {7'b0, q3}, 8'h00);
        #5  d1 = 1'b1;
        #2  reset_n = 1'b1; d1 = 1'b1; d8 = 8'h3C; d3 = 1'b0;   // t=27

        // Capture sequence 1,0,1,1,0 on the default flop, 3C/FF/00 on the 8-bit.
        @(posedge clk); #1 d1 = 1'b0; d8 = 8'hFF;          // edge 30 sampled 1 / 3C
        @(negedge clk);
        chk("cap_q1_1", {7'b0, q1}, 8'h01);
        chk("w8_3c", q8, 8'h3C);
        chk("dl_idle0", {7'b0, q3}, 8'h00);
        @(posedge clk); #1 d1 = 1'b1; d8 = 8'h00;          // edge 50 sampled 0 / FF
        @(negedge clk);
        chk("cap_q1_2", {7'b0, q1}, 8'h00);
        chk("w8_ff", q8, 8'hFF);
        @(posedge clk); #1 d1 = 1'b1;                      // edge 70 sampled 1 / 00
        @(negedge clk);
        chk("cap_q1_3", {7'b0, q1}, 8'h01);
        chk("w8_00", q8, 8'h00);
        @(posedge clk); #1 d1 = 1'b0;                      // edge 90 sampled 1
        @(negedge clk);
        chk("cap_q1_4", {7'b0, q1}, 8'h01);
        @(posedge clk); #1 d1 = 1'b1; d3 = 1'b1;           // edge 110 sampled 0
        @(negedge clk);
        chk("cap_q1_5", {7'b0, q1}, 8'h00);

        // Single-cycle pulse into the 3-stage line, sampled at edge 130.
        @(posedge clk); #1 d3 = 1'b0;
        @(negedge clk);                                    // t=140
        chk("dl_pulse_s0", {7'b0, q3}, 8'h00);
        chk("q1_high", {7'b0, q1}, 8'h01);
        @(negedge clk);                                    // t=160
        chk("dl_pulse_s1", {7'b0, q3}, 8'h00);
        @(negedge clk);                                    // t=180, after edge 170
        chk("dl_pulse_out", {7'b0, q3}, 8'h01);
        @(posedge clk); #1 d3 = 1'b1;                      // edge 190 clears output
        @(negedge clk);                                    // t=200
        chk("dl_pulse_end", {7'b0, q3}, 8'h00);

        // Second pulse sampled at edge 210, then asynchronous reset mid-flight.
        @(posedge clk); #1 d3 = 1'b0;                      // t=211
        chk("pre_rst_q1", {7'b0, q1}, 8'h01);
        #4  reset_n = 1'b0;                                // t=215, between edges
        #1  chk("async_rst_q1", {7'b0, q1}, 8'h00);
            chk("async_rst_q8", q8, 8'hA5);
            d8 = 8'h5A;
        @(negedge clk);                                    // t=220
        chk("rst_hold_q1", {7'b0, q1}, 8'h00);
        #5  reset_n = 1'b1;                                // t=225
        @(negedge clk);                                    // t=240, after edge 230
        chk("rel_load_q1", {7'b0, q1}, 8'h01);
        chk("rel_load_q8", q8, 8'h5A);
        chk("dl_cleared0", {7'b0, q3}, 8'h00);
        @(negedge clk);                                    // t=260
        chk("dl_cleared1", {7'b0, q3}, 8'h00);
        @(negedge clk);                                    // t=280
        chk("dl_cleared2", {7'b0, q3}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_d_flip_flop
